// File: rtl/branch_resolver.sv
// Branch prediction tracker: queues in-flight predictions at fetch,
// checks them at EX resolve, drives BTB write-back and flush/redirect.
//
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   fetch_valid/fetch_pc           push request and PC of the fetched instr
//   pred_taken/pred_target         BTB prediction for fetch_pc
//   res_valid/res_is_branch        pop request (oldest instr resolves)
//   res_taken/res_target           actual branch outcome and target
//   full                           queue holds DEPTH entries
//   wen/pc_w/target_w/taken_w      BTB update, one-cycle pulse
//   flush/redirect_pc              mispredict squash and correct next PC
//   mispredict_count               saturating mispredict counter
//   error                          sticky pop-while-empty flag
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_pc,
    input  logic            pred_taken,
    input  logic [31:0]     pred_target,
    input  logic            res_valid,
    input  logic            res_is_branch,
    input  logic            res_taken,
    input  logic [31:0]     res_target,
    output logic            full,
    output logic            wen,
    output logic [31:0]     pc_w,
    output logic [31:0]     target_w,
    output logic            taken_w,
    output logic            flush,
    output logic [31:0]     redirect_pc,
    output logic [CNTW-1:0] mispredict_count,
    output logic            error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

    logic [31:0]   q_pc  [DEPTH];
    logic          q_pt  [DEPTH];
    logic [31:0]   q_tgt [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic        pop;
    logic        push;
    logic        bad_pop;
    logic        mis;
    logic [31:0] head_pc;
    logic [31:0] pc_inc;
    logic [31:0] pred_next;
    logic [31:0] act_next;

    assign full = (count == FULLC);

    // While flush is high the pipeline is presenting wrong-path work,
    // so both ends of the queue are frozen.
    always_comb begin
        pop       = res_valid && !flush && (count != '0);
        bad_pop   = res_valid && !flush && (count == '0);
        push      = fetch_valid && !flush && (!full || pop);
        head_pc   = q_pc[rd_ptr];
        pc_inc    = head_pc + 32'd4;
        pred_next = q_pt[rd_ptr] ? q_tgt[rd_ptr] : pc_inc;
        act_next  = (res_is_branch && res_taken) ? res_target : pc_inc;
        mis       = pop && (pred_next != act_next);
    end

    // Payload storage needs no reset; count/pointers define validity.
    always_ff @(posedge CLK) begin
        if (push && !mis) begin
            q_pc[wr_ptr]  <= fetch_pc;
            q_pt[wr_ptr]  <= pred_taken;
            q_tgt[wr_ptr] <= pred_target;
        end
    end

    // Queue control. A mispredict empties the queue at the same edge
    // that raises flush, so a same-cycle push is discarded.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mis) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Registered resolve outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wen              <= 1'b0;
            pc_w             <= '0;
            target_w         <= '0;
            taken_w          <= 1'b0;
            flush            <= 1'b0;
            redirect_pc      <= '0;
            mispredict_count <= '0;
            error            <= 1'b0;
        end else begin
            wen   <= pop && res_is_branch;
            flush <= mis;
            if (pop && res_is_branch) begin
                pc_w     <= head_pc;
                target_w <= res_target;
                taken_w  <= res_taken;
            end
            if (mis) begin
                redirect_pc <= act_next;
                if (mispredict_count != '1)
                    mispredict_count <= mispredict_count + 1'b1;
            end
            if (bad_pop) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table,
// randomized run against a queue-level reference model, reset corner.
module tb_branch_resolver;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_is_branch;
    logic        res_taken;
    logic [31:0] res_target;

    logic        full, wen, taken_w, flush, error;
    logic [31:0] pc_w, target_w, redirect_pc;
    logic [15:0] mispredict_count;

    logic        s_full, s_wen, s_taken_w, s_flush, s_error;
    logic [31:0] s_pc_w, s_target_w, s_redirect_pc;
    logic [2:0]  s_mcnt;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    branch_resolver #(.DEPTH(DEPTH), .CNTW(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_is_branch(res_is_branch),
        .res_taken(res_taken), .res_target(res_target),
        .full(full), .wen(wen), .pc_w(pc_w), .target_w(target_w),
        .taken_w(taken_w), .flush(flush), .redirect_pc(redirect_pc),
        .mispredict_count(mispredict_count), .error(error)
    );

    // Narrow counter copy: saturation is reachable within the run.
    branch_resolver #(.DEPTH(DEPTH), .CNTW(3)) dut_sat (
        .CLK(CLK), .nRST(nRST),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_is_branch(res_is_branch),
        .res_taken(res_taken), .res_target(res_target),
        .full(s_full), .wen(s_wen), .pc_w(s_pc_w), .target_w(s_target_w),
        .taken_w(s_taken_w), .flush(s_flush), .redirect_pc(s_redirect_pc),
        .mispredict_count(s_mcnt), .error(s_error)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        m_wen, m_flush, m_tkw, m_err;
    logic [31:0] m_pcw, m_tgtw, m_rpc;
    int          m_cnt;

    task automatic model_clear();
        q.delete();
        m_wen = 0; m_flush = 0; m_tkw = 0; m_err = 0;
        m_pcw = 0; m_tgtw = 0; m_rpc = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        ent_t        h;
        ent_t        e;
        logic [31:0] pn, an;
        bit          live, do_pop, do_push, mis;
        live    = !m_flush;
        do_pop  = live && res_valid && q.size() != 0;
        do_push = live && fetch_valid && (q.size() < DEPTH || do_pop);
        mis     = 0;
        m_wen   = 0;
        m_flush = 0;
        if (live && res_valid && q.size() == 0) m_err = 1;
        if (do_pop) begin
            h  = q[0];
            pn = h.pt ? h.tgt : h.pc + 32'd4;
            an = (res_is_branch && res_taken) ? res_target : h.pc + 32'd4;
            if (res_is_branch) begin
                m_wen = 1; m_pcw = h.pc; m_tgtw = res_target; m_tkw = res_taken;
            end
            if (pn != an) begin
                mis = 1; m_flush = 1; m_rpc = an;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        if (mis) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc = fetch_pc; e.pt = pred_taken; e.tgt = pred_target;
                q.push_back(e);
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic idle();
        fetch_valid = 0; fetch_pc = 0; pred_taken = 0; pred_target = 0;
        res_valid = 0; res_is_branch = 0; res_taken = 0; res_target = 0;
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic cmp_model();
        int sat;
        sat = (m_cnt > 7) ? 7 : m_cnt;
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("wen", 32'(wen), 32'(m_wen));
        chk("flush", 32'(flush), 32'(m_flush));
        chk("error", 32'(error), 32'(m_err));
        chk("mcnt", 32'(mispredict_count), 32'(m_cnt));
        chk("mcnt_sat", 32'(s_mcnt), 32'(sat));
        if (m_wen) begin
            chk("pc_w", pc_w, m_pcw);
            chk("target_w", target_w, m_tgtw);
            chk("taken_w", 32'(taken_w), 32'(m_tkw));
        end
        if (m_flush) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        pt;
        logic [31:0] ptgt;
        logic        rv, rb, rt;
        logic [31:0] rtgt;
        logic        ew, ef, efull;
        logic [31:0] epcw, etw;
        logic        etk;
        logic [31:0] erpc;
        int          emc;
        logic        eerr;
    } vec_t;

    function automatic vec_t mk(
        input logic fv, input logic [31:0] fpc, input logic pt, input logic [31:0] ptgt,
        input logic rv, input logic rb, input logic rt, input logic [31:0] rtgt,
        input logic ew, input logic ef, input logic efull,
        input logic [31:0] epcw, input logic [31:0] etw, input logic etk,
        input logic [31:0] erpc, input int emc, input logic eerr);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.pt = pt; v.ptgt = ptgt;
        v.rv = rv; v.rb = rb; v.rt = rt; v.rtgt = rtgt;
        v.ew = ew; v.ef = ef; v.efull = efull; v.epcw = epcw; v.etw = etw;
        v.etk = etk; v.erpc = erpc; v.emc = emc; v.eerr = eerr;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        idle();
        tv.push_back(mk(1,'h100,0,0,     0,0,0,0,      0,0,0,0,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,         1,0,0,0,      0,0,0,0,0,0,0,0,0));
        tv.push_back(mk(1,'h200,1,'h240, 0,0,0,0,      0,0,0,0,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,         1,1,1,'h240,  1,0,0,'h200,'h240,1,0,0,0));
        tv.push_back(mk(1,'h300,0,0,     0,0,0,0,      0,0,0,0,0,0,0,0,0));
        tv.push_back(mk(1,'h304,0,0,     0,0,0,0,      0,0,0,0,0,0,0,0,0));
        tv.push_back(mk(1,'h308,0,0,     0,0,0,0,      0,0,0,0,0,0,0,0,0));
        tv.push_back(mk(1,'h30c,0,0,     0,0,0,0,      0,0,1,0,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,         1,1,1,'h380,  1,1,0,'h300,'h380,1,'h380,1,0));
        tv.push_back(mk(1,'h998,0,0,     1,1,1,'h50,   0,0,0,0,0,0,0,1,0));
        tv.push_back(mk(0,0,0,0,         1,0,0,0,      0,0,0,0,0,0,0,1,1));
        tv.push_back(mk(1,'h400,1,'h500, 0,0,0,0,      0,0,0,0,0,0,0,1,1));
        tv.push_back(mk(0,0,0,0,         1,1,0,'h124,  1,1,0,'h400,'h124,0,'h404,2,1));
        tv.push_back(mk(0,0,0,0,         0,0,0,0,      0,0,0,0,0,0,0,2,1));
        tv.push_back(mk(1,'h10,0,0,      0,0,0,0,      0,0,0,0,0,0,0,2,1));
        tv.push_back(mk(1,'h14,0,0,      0,0,0,0,      0,0,0,0,0,0,0,2,1));
        tv.push_back(mk(1,'h18,0,0,      0,0,0,0,      0,0,0,0,0,0,0,2,1));
        tv.push_back(mk(1,'h1c,0,0,      0,0,0,0,      0,0,1,0,0,0,0,2,1));
        tv.push_back(mk(1,'h20,0,0,      1,0,0,0,      0,0,1,0,0,0,0,2,1));
        tv.push_back(mk(1,'h24,0,0,      1,1,0,0,      1,0,1,'h14,0,0,0,2,1));
        tv.push_back(mk(0,0,0,0,         1,1,0,0,      1,0,0,'h18,0,0,0,2,1));
        tv.push_back(mk(0,0,0,0,         1,1,0,0,      1,0,0,'h1c,0,0,0,2,1));
        tv.push_back(mk(0,0,0,0,         1,1,0,0,      1,0,0,'h20,0,0,0,2,1));
        tv.push_back(mk(0,0,0,0,         1,1,0,0,      1,0,0,'h24,0,0,0,2,1));

        // Reset state
        model_clear();
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        chk("rst_full", 32'(full), 0);
        chk("rst_wen", 32'(wen), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_pc_w", pc_w, 0);
        chk("rst_target_w", target_w, 0);
        chk("rst_taken_w", 32'(taken_w), 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_mcnt", 32'(mispredict_count), 0);
        chk("rst_error", 32'(error), 0);

        foreach (tv[i]) begin
            fetch_valid = tv[i].fv; fetch_pc = tv[i].fpc;
            pred_taken = tv[i].pt; pred_target = tv[i].ptgt;
            res_valid = tv[i].rv; res_is_branch = tv[i].rb;
            res_taken = tv[i].rt; res_target = tv[i].rtgt;
            step();
            chk($sformatf("v%0d_wen", i), 32'(wen), 32'(tv[i].ew));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tv[i].ef));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].efull));
            chk($sformatf("v%0d_mcnt", i), 32'(mispredict_count), 32'(tv[i].emc));
            chk($sformatf("v%0d_error", i), 32'(error), 32'(tv[i].eerr));
            if (tv[i].ew) begin
                chk($sformatf("v%0d_pc_w", i), pc_w, tv[i].epcw);
                chk($sformatf("v%0d_target_w", i), target_w, tv[i].etw);
                chk($sformatf("v%0d_taken_w", i), 32'(taken_w), 32'(tv[i].etk));
            end
            if (tv[i].ef)
                chk($sformatf("v%0d_redirect", i), redirect_pc, tv[i].erpc);
        end
        idle();

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r;
            r = $urandom();
            fetch_valid   = r[0] | r[1];
            fetch_pc      = r[5:2] == 0 ? 32'hFFFF_FFFC : 32'h1000 + 32'(r[7:6]) * 4;
            pred_taken    = r[8];
            pred_target   = 32'h1000 + 32'(r[10:9]) * 4;
            res_valid     = r[11] | r[12];
            res_is_branch = r[13] | r[14];
            res_taken     = r[15];
            res_target    = r[18:16] == 0 ? 32'h0 : 32'h1000 + 32'(r[20:19]) * 4;
            step();
            cmp_model();
        end
        idle();
        step();
        cmp_model();

        // Reset in the middle of a pending flush pulse
        fetch_valid = 1; fetch_pc = 'h500;
        step();
        idle();
        res_valid = 1; res_is_branch = 1; res_taken = 1; res_target = 'h600;
        step();
        chk("pre_rst_flush", 32'(flush), 1);
        idle();
        #2 nRST = 0;
        #1;
        model_clear();
        chk("mid_rst_flush", 32'(flush), 0);
        chk("mid_rst_wen", 32'(wen), 0);
        chk("mid_rst_redirect", redirect_pc, 0);
        chk("mid_rst_pc_w", pc_w, 0);
        chk("mid_rst_mcnt", 32'(mispredict_count), 0);
        chk("mid_rst_sat", 32'(s_mcnt), 0);
        chk("mid_rst_error", 32'(error), 0);
        chk("mid_rst_full", 32'(full), 0);
        @(posedge CLK);
        #1 nRST = 1;

        // Push then immediate pop from empty, then a pop on empty
        fetch_valid = 1; fetch_pc = 'h700; pred_taken = 1; pred_target = 'h740;
        step();
        cmp_model();
        idle();
        res_valid = 1; res_is_branch = 1; res_taken = 1; res_target = 'h740;
        step();
        cmp_model();
        chk("post_rst_pc_w", pc_w, 'h700);
        res_is_branch = 0;
        step();
        cmp_model();
        chk("empty_pop_error", 32'(error), 1);
        idle();
        repeat (3) step();
        chk("error_sticky", 32'(error), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
